// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the EX-stage trap sequencer and the machine CSR file.
package trap_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  // Sequencer states; encoding is shared with debug/trace tooling.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  // Latched trap kind.
  localparam logic KIND_ECALL = 1'b0;
  localparam logic KIND_MRET  = 1'b1;

  // mcause code written by the CSR file for an environment call from M-mode.
  localparam logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(11);

  // Redirect targets are word aligned; low bits (mtvec mode) are dropped.
  function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/trap_ctrl_outstanding_cnt.sv
// Saturating up/down counter of in-flight data-memory operations with sticky overflow.
module trap_ctrl_outstanding_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Issue/complete in the same cycle cancel; no underflow; saturate at max and flag it.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      unique case ({inc, dec})
        2'b10: begin
          if (count == CNT_MAX) begin
            ovf <= 1'b1;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        2'b01: begin
          if (count != '0) begin
            count <= count - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// EX-stage trap sequencer: stall on ecall/mret, drain memory, pulse the CSR file, redirect fetch.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            ex_is_ecall,
  input  logic            ex_is_mret,
  input  logic [XLEN-1:0] ex_pc,
  output logic            ex_ready,
  input  logic            mem_issue,
  input  logic            mem_done,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            do_ecall,
  output logic            do_mret,
  output logic [XLEN-1:0] cur_pc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            busy,
  output logic            cnt_ovf
);

  state_t           state_q;
  state_t           state_d;
  logic             kind_q;
  logic [CNT_W-1:0] outstanding;
  logic             trap_det_c;
  logic             drained_c;

  trap_ctrl_outstanding_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (mem_issue),
    .dec   (mem_done),
    .count (outstanding),
    .ovf   (cnt_ovf)
  );

  assign trap_det_c = ex_valid & (ex_is_ecall | ex_is_mret);
  // A request accepted this cycle is still outstanding next cycle, so it blocks the drain.
  assign drained_c  = (outstanding == '0) & ~mem_issue;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and redirect target (targets read live so COMMIT's CSR writes are seen).
  always_comb begin
    state_d     = state_q;
    ex_ready    = 1'b0;
    redirect_pc = '0;
    unique case (state_q)
      ST_IDLE: begin
        ex_ready = ~trap_det_c;
        if (trap_det_c) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drained_c) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_d = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        redirect_pc = align4((kind_q == KIND_MRET) ? mepc_in : mtvec_in);
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the trapping instruction's kind and PC; ecall wins when both flags are set.
  always_ff @(posedge clk) begin
    if (rst) begin
      kind_q <= KIND_ECALL;
      cur_pc <= '0;
    end else if ((state_q == ST_IDLE) && trap_det_c) begin
      kind_q <= ex_is_ecall ? KIND_ECALL : KIND_MRET;
      cur_pc <= ex_pc;
    end
  end

  // Registered strobes decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_ecall       <= 1'b0;
      do_mret        <= 1'b0;
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      do_ecall       <= (state_d == ST_COMMIT) && (kind_q == KIND_ECALL);
      do_mret        <= (state_d == ST_COMMIT) && (kind_q == KIND_MRET);
      redirect_valid <= (state_d == ST_REDIRECT);
      flush          <= (state_d == ST_REDIRECT);
      busy           <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed table, corner sequences, randomized run vs model.
module tb_trap_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = 15;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_is_ecall, ex_is_mret;
  logic [31:0] ex_pc;
  logic        ex_ready;
  logic        mem_issue, mem_done;
  logic [31:0] mtvec_in, mepc_in;
  logic        do_ecall, do_mret;
  logic [31:0] cur_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush, busy, cnt_ovf;

  trap_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_is_ecall    (ex_is_ecall),
    .ex_is_mret     (ex_is_mret),
    .ex_pc          (ex_pc),
    .ex_ready       (ex_ready),
    .mem_issue      (mem_issue),
    .mem_done       (mem_done),
    .mtvec_in       (mtvec_in),
    .mepc_in        (mepc_in),
    .do_ecall       (do_ecall),
    .do_mret        (do_mret),
    .cur_pc         (cur_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .busy           (busy),
    .cnt_ovf        (cnt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
  endtask

  // Reference model: trap timeline (commit/redirect cycle numbers) plus an integer counter.
  bit          m_pend;
  bit          m_mret;
  logic [31:0] m_pc;
  int          m_out;
  bit          m_ovf;
  int          m_commit;
  int          m_redir;
  bit          mchk_en;

  task automatic model_check();
    bit          det, commit_now, redir_now;
    logic [31:0] tgt;
    det        = ex_valid && (ex_is_ecall || ex_is_mret);
    commit_now = m_pend && (cyc == m_commit);
    redir_now  = m_pend && (cyc == m_redir);
    tgt        = redir_now ? ((m_mret ? mepc_in : mtvec_in) & 32'hFFFF_FFFC) : 32'h0;
    chk1 ("m_ex_ready", ex_ready, !m_pend && !det);
    chk1 ("m_busy", busy, m_pend);
    chk1 ("m_do_ecall", do_ecall, commit_now && !m_mret);
    chk1 ("m_do_mret", do_mret, commit_now && m_mret);
    chk1 ("m_redirect_valid", redirect_valid, redir_now);
    chk1 ("m_flush", flush, redir_now);
    chk32("m_redirect_pc", redirect_pc, tgt);
    chk32("m_cur_pc", cur_pc, m_pc);
    chk1 ("m_cnt_ovf", cnt_ovf, m_ovf);
  endtask

  task automatic model_update();
    if (rst) begin
      m_pend = 0; m_mret = 0; m_pc = 32'h0; m_out = 0; m_ovf = 0;
      m_commit = -1; m_redir = -1;
    end else begin
      if (m_pend) begin
        if (cyc == m_redir) m_pend = 0;
        else if (m_commit < 0 && m_out == 0 && !mem_issue) begin
          m_commit = cyc + 1;
          m_redir  = cyc + 2;
        end
      end else if (ex_valid && (ex_is_ecall || ex_is_mret)) begin
        m_pend = 1; m_mret = !ex_is_ecall; m_pc = ex_pc;
        m_commit = -1; m_redir = -1;
      end
      if (mem_issue && !mem_done) begin
        if (m_out == CNT_MAX) m_ovf = 1;
        else m_out++;
      end else if (mem_done && !mem_issue && m_out > 0) begin
        m_out--;
      end
    end
  endtask

  typedef struct {
    bit          v, e, m;
    logic [31:0] pc;
    bit          rdy, dec, dmr, rv, fl, bsy;
    logic [31:0] rpc, cpc;
  } vec_t;

  function automatic vec_t mk(bit v, bit e, bit m, logic [31:0] pc, bit rdy, bit dec, bit dmr,
                              bit rv, bit fl, bit bsy, logic [31:0] rpc, logic [31:0] cpc);
    vec_t t;
    t.v = v; t.e = e; t.m = m; t.pc = pc;
    t.rdy = rdy; t.dec = dec; t.dmr = dmr; t.rv = rv; t.fl = fl; t.bsy = bsy;
    t.rpc = rpc; t.cpc = cpc;
    return t;
  endfunction

  bit   tbl_act;
  vec_t tbl_cur;
  logic obs_dec, obs_dmr, obs_rv, obs_busy, obs_ovf, obs_rdy;
  logic [31:0] obs_cpc;

  task automatic table_check();
    chk1 ("tbl_ex_ready", ex_ready, tbl_cur.rdy);
    chk1 ("tbl_do_ecall", do_ecall, tbl_cur.dec);
    chk1 ("tbl_do_mret", do_mret, tbl_cur.dmr);
    chk1 ("tbl_redirect_valid", redirect_valid, tbl_cur.rv);
    chk1 ("tbl_flush", flush, tbl_cur.fl);
    chk1 ("tbl_busy", busy, tbl_cur.bsy);
    chk32("tbl_redirect_pc", redirect_pc, tbl_cur.rpc);
    chk32("tbl_cur_pc", cur_pc, tbl_cur.cpc);
  endtask

  // One clock: check mid-cycle, then advance the model on the active edge.
  task automatic step();
    @(negedge clk);
    obs_dec = do_ecall; obs_dmr = do_mret; obs_rv = redirect_valid;
    obs_busy = busy; obs_ovf = cnt_ovf; obs_rdy = ex_ready; obs_cpc = cur_pc;
    if (mchk_en) model_check();
    if (tbl_act) table_check();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic set_ex(input bit v, input bit e, input bit m, input logic [31:0] pc);
    ex_valid = v; ex_is_ecall = e; ex_is_mret = m; ex_pc = pc;
  endtask

  task automatic quiet(input int n);
    set_ex(0, 0, 0, 32'h0); mem_issue = 0; mem_done = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  vec_t vec[$];
  int   first, pulses;

  initial begin
    rst = 1; set_ex(0, 0, 0, 32'h0); mem_issue = 0; mem_done = 0;
    mtvec_in = 32'h0000_0103; mepc_in = 32'h0000_0084;
    tbl_act = 0; mchk_en = 0;
    step(); step();
    rst = 0; mchk_en = 1;

    // Directed table: reset state, ecall, mret, both flags, ex_valid=0 ignored.
    vec.push_back(mk(0,0,0,32'h0,   1,0,0,0,0,0, 32'h0,   32'h0));
    vec.push_back(mk(1,1,0,32'h80,  0,0,0,0,0,0, 32'h0,   32'h0));
    vec.push_back(mk(0,0,0,32'h0,   0,0,0,0,0,1, 32'h0,   32'h80));
    vec.push_back(mk(0,0,0,32'h0,   0,1,0,0,0,1, 32'h0,   32'h80));
    vec.push_back(mk(0,0,0,32'h0,   0,0,0,1,1,1, 32'h100, 32'h80));
    vec.push_back(mk(0,0,0,32'h0,   1,0,0,0,0,0, 32'h0,   32'h80));
    vec.push_back(mk(1,0,1,32'h200, 0,0,0,0,0,0, 32'h0,   32'h80));
    vec.push_back(mk(1,1,0,32'h999, 0,0,0,0,0,1, 32'h0,   32'h200));
    vec.push_back(mk(0,0,0,32'h0,   0,0,1,0,0,1, 32'h0,   32'h200));
    vec.push_back(mk(0,0,0,32'h0,   0,0,0,1,1,1, 32'h84,  32'h200));
    vec.push_back(mk(0,0,0,32'h0,   1,0,0,0,0,0, 32'h0,   32'h200));
    vec.push_back(mk(1,1,1,32'h300, 0,0,0,0,0,0, 32'h0,   32'h200));
    vec.push_back(mk(0,0,0,32'h0,   0,0,0,0,0,1, 32'h0,   32'h300));
    vec.push_back(mk(0,0,0,32'h0,   0,1,0,0,0,1, 32'h0,   32'h300));
    vec.push_back(mk(0,0,0,32'h0,   0,0,0,1,1,1, 32'h100, 32'h300));
    vec.push_back(mk(0,1,0,32'h400, 1,0,0,0,0,0, 32'h0,   32'h300));
    vec.push_back(mk(0,0,1,32'h404, 1,0,0,0,0,0, 32'h0,   32'h300));
    foreach (vec[i]) begin
      set_ex(vec[i].v, vec[i].e, vec[i].m, vec[i].pc);
      mem_issue = 0; mem_done = 0;
      tbl_cur = vec[i]; tbl_act = 1;
      step();
      tbl_act = 0;
    end

    // Drain wait: two issues, ecall, completions at +3 and +6 -> do_ecall at +8.
    quiet(1);
    mem_issue = 1; step(); step(); mem_issue = 0;
    set_ex(1, 1, 0, 32'h500); step();
    set_ex(0, 0, 0, 32'h0);
    first = -1; pulses = 0;
    for (int k = 1; k <= 14; k++) begin
      mem_done = (k == 3 || k == 6);
      step();
      if (obs_dec) begin pulses++; if (first < 0) first = k; end
    end
    mem_done = 0;
    chk32("drain_first_pulse", first, 32'd8);
    chk32("drain_pulse_count", pulses, 32'd1);

    // Issue and done together at count 1 keeps 1; done at count 0 is ignored.
    mem_done = 1; step(); mem_done = 0;
    mem_issue = 1; step();
    mem_done = 1; step(); mem_issue = 0; mem_done = 0;
    set_ex(1, 1, 0, 32'h540); step(); set_ex(0, 0, 0, 32'h0);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin step(); if (obs_dec) pulses++; end
    chk32("cnt_hold_one_no_commit", pulses, 32'd0);
    mem_done = 1; step(); mem_done = 0;
    first = -1;
    for (int k = 1; k <= 6; k++) begin step(); if (obs_dec && first < 0) first = k; end
    chk32("cnt_hold_one_commit", first, 32'd2);
    quiet(2);

    // Overflow: 16 issues saturate at 15 and set the sticky flag.
    mem_issue = 1;
    for (int k = 0; k < 16; k++) step();
    mem_issue = 0; step();
    chk1("ovf_set", obs_ovf, 1'b1);
    mem_done = 1;
    for (int k = 0; k < 14; k++) step();
    mem_done = 0;
    set_ex(1, 1, 0, 32'h900); step(); set_ex(0, 0, 0, 32'h0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin step(); if (obs_dec) pulses++; end
    chk32("ovf_saturated_drain", pulses, 32'd0);
    mem_done = 1; step(); mem_done = 0;
    first = -1;
    for (int k = 1; k <= 6; k++) begin step(); if (obs_dec && first < 0) first = k; end
    chk32("ovf_final_commit", first, 32'd2);
    chk1("ovf_sticky", obs_ovf, 1'b1);
    rst = 1; step(); rst = 0; step();
    chk1("ovf_cleared", obs_ovf, 1'b0);

    // Reset during DRAIN aborts the sequence with no later pulse.
    mem_issue = 1; step(); step(); mem_issue = 0;
    set_ex(1, 1, 0, 32'hA00); step(); set_ex(0, 0, 0, 32'h0);
    step();
    rst = 1; step(); rst = 0;
    step();
    chk1("abort_busy", obs_busy, 1'b0);
    chk1("abort_ex_ready", obs_rdy, 1'b1);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin step(); if (obs_dec || obs_dmr) pulses++; end
    chk32("abort_no_pulse", pulses, 32'd0);

    // Back-to-back: ex_* changes in DRAIN ignored; held ecall restarts after REDIRECT.
    mem_issue = 1; step(); mem_issue = 0;
    set_ex(1, 1, 0, 32'h600); step();
    set_ex(1, 1, 0, 32'h700); step(); step();
    chk32("b2b_latched_pc", obs_cpc, 32'h600);
    set_ex(1, 1, 0, 32'h800);
    mem_done = 1; step(); mem_done = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 3) chk1("b2b_redirect", obs_rv, 1'b1);
      if (k == 5) begin
        chk32("b2b_new_pc", obs_cpc, 32'h800);
        chk1("b2b_new_busy", obs_busy, 1'b1);
      end
    end
    quiet(6);

    // Randomized run against the model.
    for (int k = 0; k < 3000; k++) begin
      ex_valid    = ($urandom_range(2, 0) == 0);
      ex_is_ecall = ($urandom_range(1, 0) == 1);
      ex_is_mret  = ($urandom_range(1, 0) == 1);
      ex_pc       = $urandom;
      mem_issue   = ($urandom_range(2, 0) == 0);
      mem_done    = ($urandom_range(2, 0) == 0);
      mtvec_in    = $urandom;
      mepc_in     = $urandom;
      rst         = ($urandom_range(199, 0) == 0);
      step();
    end
    rst = 0;
    quiet(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer in the EX stage, directly upstream of the machine CSR file.
- Detects ecall/mret in EX and stalls the front of the pipeline.
- Waits for outstanding data-memory operations to drain, then issues a one-cycle do_ecall/do_mret pulse with the trapping PC to the CSR file.
- On the following cycle it redirects fetch to mtvec (ecall) or mepc (mret) and flushes younger instructions.

Parameters:
- CNT_W, 4, width of the outstanding-memory-operation counter; maximum count is 2^CNT_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  1  valid instruction in EX
- ex_is_ecall  in  1  EX instruction is ecall
- ex_is_mret  in  1  EX instruction is mret
- ex_pc  in  32  PC of EX instruction
- ex_ready  out  1  EX may advance; 0 = stall IF/ID/EX
- mem_issue  in  1  data-memory request accepted this cycle
- mem_done  in  1  data-memory response/completion this cycle
- mtvec_in  in  32  mtvec value from CSR file
- mepc_in  in  32  mepc value from CSR file
- do_ecall  out  1  to CSR file: take ecall trap
- do_mret  out  1  to CSR file: return from trap
- cur_pc  out  32  to CSR file: PC saved into mepc
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  fetch redirect target
- flush  out  1  kill IF/ID/EX contents
- busy  out  1  FSM not in IDLE
- cnt_ovf  out  1  sticky outstanding-counter overflow error

Behaviour:
- Reset:
  - state = IDLE, outstanding = 0, cnt_ovf = 0.
  - do_ecall, do_mret, redirect_valid, flush, busy = 0; cur_pc = 0; redirect_pc = 0; ex_ready = 1.
  - Reset mid-sequence aborts immediately; no pulse is issued afterwards.
- Outstanding counter, every cycle in any state:
  - +1 on mem_issue, -1 on mem_done.
  - Both asserted in the same cycle: unchanged.
  - mem_done at 0: ignored, no underflow.
  - mem_issue at max without mem_done: saturate and set cnt_ovf, which holds until rst.
- FSM states:
  - IDLE: ex_ready = 1. If ex_valid & (ex_is_ecall | ex_is_mret):
    - latch kind (ecall has priority if both are set) and latch ex_pc into cur_pc;
    - ex_ready = 0 combinationally in that same cycle;
    - next state = DRAIN.
  - DRAIN: ex_ready = 0. Advance to COMMIT when outstanding == 0 and mem_issue == 0 in the current cycle; otherwise stay.
  - COMMIT: ex_ready = 0. Assert exactly one of do_ecall/do_mret for exactly one cycle; cur_pc holds the latched PC. Next state = REDIRECT.
  - REDIRECT: redirect_valid = 1 and flush = 1 for one cycle; ex_ready = 0. Next state = IDLE.
    - Target for ecall: {mtvec_in[31:2], 2'b00}. Only direct mode is supported; mode bits are ignored.
    - Target for mret: {mepc_in[31:2], 2'b00}.
    - Targets are sampled in REDIRECT so the CSR updates from COMMIT are visible.
- Minimum latency, trap detect to redirect, with nothing outstanding: detect cycle N (IDLE) -> DRAIN N+1 -> COMMIT N+2 -> REDIRECT N+3.
- The trapping instruction is consumed by the REDIRECT flush; it does not retire as a normal instruction.
- busy = 1 in DRAIN, COMMIT and REDIRECT.
- ex_is_* with ex_valid = 0: ignored.
- ex_* inputs while not in IDLE: ignored; the latched values are used.
- do_ecall, do_mret, redirect_valid and flush are registered (state-decoded) outputs, never combinational from inputs. Only ex_ready has a combinational path from ex_valid/ex_is_*.

Decomposition:
- Shared package/define file:
  - FSM state encoding (IDLE = 2'd0, DRAIN = 2'd1, COMMIT = 2'd2, REDIRECT = 2'd3);
  - trap-kind constant (KIND_ECALL = 1'b0, KIND_MRET = 1'b1);
  - the ecall mcause code 11 shared with the CSR file.
- One natural sub-module: outstanding_cnt, a saturating up/down counter with sticky overflow, parameterised by CNT_W.

Test Plan:
- Basic ecall: rst 2 cycles; mtvec_in = 0x00000103, ex_valid = 1, ex_is_ecall = 1, ex_pc = 0x80; outstanding = 0 -> do_ecall = 1 at cycle+2 with cur_pc = 0x80; redirect_valid = 1, redirect_pc = 0x100, flush = 1 at cycle+3; ex_ready = 0 from cycle 0 to cycle+3.
- Drain wait: 2 mem_issue before the ecall, mem_done at +3 and +6 -> FSM stays in DRAIN; do_ecall asserts exactly 1 cycle after outstanding returns to 0, with no earlier pulse.
- mret: ex_is_mret = 1, ex_pc = 0x200, mepc_in = 0x84 -> do_mret single pulse, do_ecall never set, redirect_pc = 0x84.
- Counter edges: mem_issue & mem_done together at count 1 -> count stays 1; mem_done at 0 -> stays 0; 16 mem_issue with CNT_W = 4 -> count = 15, cnt_ovf = 1 until rst.
- Both flags and reset abort: ex_is_ecall = ex_is_mret = 1 -> ecall path taken. Separately, rst asserted during DRAIN -> next cycle state IDLE, busy = 0, ex_ready = 1, and no do_* pulse ever appears.
- Back-to-back: second ecall present on ex_* in the cycle after REDIRECT -> a new sequence starts with the new ex_pc; ex_* changes during DRAIN do not alter cur_pc.
